// File: rtl/reg_file_if.sv
// Write-back / decode port bundle for the Y86-64 register file.
// master drives writes and read ids; slave (reg_file) returns read data and the write count.
interface reg_file_if #(
  parameter int DATA_W = 64
);
  logic              W_stall;
  logic [3:0]        W_dstE;
  logic [DATA_W-1:0] W_valE;
  logic [3:0]        W_dstM;
  logic [DATA_W-1:0] W_valM;
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;
  logic [DATA_W-1:0] d_rvalA;
  logic [DATA_W-1:0] d_rvalB;
  logic [31:0]       wr_cnt;

  modport master (
    output W_stall, W_dstE, W_valE, W_dstM, W_valM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, wr_cnt
  );

  modport slave (
    input  W_stall, W_dstE, W_valE, W_dstM, W_valM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, wr_cnt
  );
endinterface

// File: rtl/reg_file.sv
// Y86-64 register file: two write ports (E, M; M wins on conflict), two combinational reads.
// Optional macro REGFILE_BYPASS_EN makes committing writes visible to reads in the same cycle.
module reg_file #(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter int                RSP_ID   = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = 64'h200
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  rf
);
  localparam logic [3:0] NREG_ID = 4'(NREG);

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic                        wr_e, wr_m;
  logic [1:0]                  inc;

  // Port enables; ids >= NREG (incl. RNONE) silently drop the write.
  always_comb begin
    wr_e = !rf.W_stall && (rf.W_dstE < NREG_ID);
    wr_m = !rf.W_stall && (rf.W_dstM < NREG_ID);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_e) regs_d[rf.W_dstE] = rf.W_valE;
    if (wr_m) regs_d[rf.W_dstM] = rf.W_valM;
    inc = {1'b0, wr_e} + {1'b0, wr_m};
    if (wr_e && wr_m && (rf.W_dstE == rf.W_dstM)) inc = 2'd1;
    cnt_d = cnt_q + {30'd0, inc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] src);
    logic [DATA_W-1:0] v;
    v = (src < NREG_ID) ? regs_q[src] : '0;
`ifdef REGFILE_BYPASS_EN
    // Write-through: M has priority, and nothing is forwarded during reset.
    if (rst_n) begin
      if (wr_m && (src == rf.W_dstM))      v = rf.W_valM;
      else if (wr_e && (src == rf.W_dstE)) v = rf.W_valE;
    end
`endif
    return v;
  endfunction

  always_comb begin
    rf.d_rvalA = rd_port(rf.d_srcA);
    rf.d_rvalB = rd_port(rf.d_srcB);
    rf.wr_cnt  = cnt_q;
  end
endmodule

// File: tb/tb_reg_file.sv
// Randomized + directed bench for reg_file; a driver queues expected reads per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(64)) rf ();
  reg_file dut (.clk(clk), .rst_n(rst_n), .rf(rf));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] cnt;
    int          id;
  } exp_t;

  exp_t        q[$];
  logic [63:0] model [15];
  logic [31:0] mcnt;
  int          total = 0;
  int          bad   = 0;
  bit          done  = 0;
  int          ncyc  = 0;

  function automatic logic [63:0] mread(input logic [3:0] s, input logic r, input logic st,
                                        input logic [3:0] de, input logic [63:0] ve,
                                        input logic [3:0] dm, input logic [63:0] vm);
    logic [63:0] v;
    v = (s < 4'd15) ? model[s] : 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (r && !st && s != 4'hF) begin
      if (s == dm) v = vm;
      else if (s == de) v = ve;
    end
`endif
    return v;
  endfunction

  // One cycle: drive, queue expected pre-edge outputs, cross the edge, update the model.
  task automatic step(input logic r, input logic st, input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm,
                      input logic [3:0] sa, input logic [3:0] sb, input bit chk);
    exp_t e;
    rst_n = r; rf.W_stall = st;
    rf.W_dstE = de; rf.W_valE = ve; rf.W_dstM = dm; rf.W_valM = vm;
    rf.d_srcA = sa; rf.d_srcB = sb;
    if (chk) begin
      e.a = mread(sa, r, st, de, ve, dm, vm);
      e.b = mread(sb, r, st, de, ve, dm, vm);
      e.cnt = mcnt; e.id = ncyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    ncyc++;
    if (!r) begin
      for (int i = 0; i < 15; i++) model[i] = (i == 4) ? 64'h200 : 64'd0;
      mcnt = 0;
    end else if (!st) begin
      if (de < 4'd15) begin model[de] = ve; mcnt++; end
      if (dm < 4'd15) begin model[dm] = vm; if (!(de == dm)) mcnt++; end
    end
  endtask

  // Monitor: outputs are combinational, so one expectation per checked cycle at negedge.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (rf.d_rvalA !== e.a) begin
          bad++; $display("FAIL rvalA cyc=%0d got=%h exp=%h", e.id, rf.d_rvalA, e.a);
        end
        total++;
        if (rf.d_rvalB !== e.b) begin
          bad++; $display("FAIL rvalB cyc=%0d got=%h exp=%h", e.id, rf.d_rvalB, e.b);
        end
        total++;
        if (rf.wr_cnt !== e.cnt) begin
          bad++; $display("FAIL wr_cnt cyc=%0d got=%0d exp=%0d", e.id, rf.wr_cnt, e.cnt);
        end
      end
    end
  end

  localparam logic [3:0] N = 4'hF;

  initial begin
    mcnt = 0;
    for (int i = 0; i < 15; i++) model[i] = 64'd0;
    rst_n = 1'b0; rf.W_stall = 1'b0;
    rf.W_dstE = N; rf.W_valE = '0; rf.W_dstM = N; rf.W_valM = '0;
    rf.d_srcA = N; rf.d_srcB = N;
    @(posedge clk); #1;
    // 1: reset state (the unchecked cycle establishes a known state)
    step(1'b0, 1'b0, N, 64'd0, N, 64'd0, 4'd4, 4'd7, 1'b0);
    step(1'b1, 1'b0, N, 64'd0, N, 64'd0, 4'd4, 4'd7, 1'b1);
    // 2: single E write
    step(1'b1, 1'b0, 4'd7, 64'd14, N, 64'd0, 4'd7, 4'd4, 1'b1);
    step(1'b1, 1'b0, N, 64'd0, N, 64'd0, 4'd7, 4'd4, 1'b1);
    // 3: same-register conflict, then two distinct writes
    step(1'b1, 1'b0, 4'd7, 64'd14, 4'd7, 64'd30, 4'd7, 4'd5, 1'b1);
    step(1'b1, 1'b0, 4'd5, 64'd10, 4'd4, 64'd2, 4'd7, 4'd5, 1'b1);
    step(1'b1, 1'b0, N, 64'd0, N, 64'd0, 4'd5, 4'd4, 1'b1);
    // 4: stall, RNONE, read of RNONE
    step(1'b1, 1'b1, 4'd3, 64'd99, 4'd3, 64'd98, 4'd3, 4'd3, 1'b1);
    step(1'b1, 1'b0, N, 64'd77, N, 64'd78, 4'd3, N, 1'b1);
    step(1'b1, 1'b0, N, 64'd0, N, 64'd0, N, 4'd3, 1'b1);
    // 5: bypass vs. stored read
    step(1'b1, 1'b0, 4'd7, 64'd22, N, 64'd0, 4'd7, 4'd7, 1'b1);
    step(1'b1, 1'b0, N, 64'd0, 4'd7, 64'd30, 4'd7, 4'd7, 1'b1);
    step(1'b1, 1'b0, 4'd2, 64'd5, N, 64'd0, 4'd7, 4'd2, 1'b1);
    // 6: reset beats a simultaneous write
    step(1'b0, 1'b0, 4'd2, 64'd55, 4'd4, 64'd66, 4'd2, 4'd4, 1'b1);
    step(1'b1, 1'b0, N, 64'd0, N, 64'd0, 4'd2, 4'd4, 1'b1);
    // Random traffic over all 16 ids, occasional stalls and resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)), {$urandom, $urandom},
           4'($urandom_range(0, 15)), {$urandom, $urandom},
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    end
    @(negedge clk); @(negedge clk);
    done = 1;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
